// File: rtl/rgb_pwm_engine.sv
// Multi-channel PWM engine: shared prescaled period counter, exact duty compare, double-buffered duties.
// Optional feature macro PWM_PHASE_STAGGER_EN: per-channel phase offsets to spread rising edges.
module rgb_pwm_engine #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [CHANNELS*WIDTH-1:0]   duty_in,
  input  logic                        duty_load,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_start,
  output logic                        update_done
);

  localparam int unsigned DW       = CHANNELS * WIDTH;
  localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FULL     = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(FULL - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       active_q, active_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic                pending_valid_q, pending_valid_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;
  logic                update_done_q, update_done_d;

  logic                tick_c;
  logic                wrap_c;
  logic [CHANNELS-1:0][WIDTH-1:0] phase_c;

  assign tick_c = enable && (pre_q == PRE_LAST);
  assign wrap_c = tick_c && (cnt_q == CNT_MAX);

  // Prescaler and period counter; both park at zero while disabled.
  always_comb begin
    pre_d          = pre_q;
    cnt_d          = cnt_q;
    period_start_d = 1'b0;
    if (!enable) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick_c) begin
      pre_d          = '0;
      cnt_d          = (cnt_q == CNT_MAX) ? '0 : WIDTH'(cnt_q + WIDTH'(1));
      period_start_d = (cnt_q == '0);
    end else begin
      pre_d = PRE_W'(pre_q + PRE_W'(1));
    end
  end

  // Double buffer: a strobe coincident with the wrap bypasses the pending stage.
  always_comb begin
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    update_done_d   = 1'b0;
    if (wrap_c && duty_load) begin
      active_d        = duty_in;
      pending_d       = duty_in;
      pending_valid_d = 1'b0;
      update_done_d   = 1'b1;
    end else if (wrap_c && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
      update_done_d   = 1'b1;
    end else if (duty_load) begin
      pending_d       = duty_in;
      pending_valid_d = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_phase
`ifdef PWM_PHASE_STAGGER_EN
      localparam int unsigned OFF = gi * (FULL / CHANNELS);
      logic [WIDTH:0] sum_c;
      // Sum of two values below FULL never reaches 2*FULL, so one subtraction suffices.
      assign sum_c = {1'b0, cnt_q} + (WIDTH+1)'(OFF);
      assign phase_c[gi] = (sum_c >= (WIDTH+1)'(FULL)) ?
                           WIDTH'(sum_c - (WIDTH+1)'(FULL)) : WIDTH'(sum_c);
`else
      assign phase_c[gi] = cnt_q;
`endif
    end
  endgenerate

  // Duty compare; full-scale duty stays high because phase never exceeds FULL-1.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = enable && (phase_c[i] < active_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q           <= '0;
      cnt_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      pwm_q           <= '0;
      period_start_q  <= 1'b0;
      update_done_q   <= 1'b0;
    end else begin
      pre_q           <= pre_d;
      cnt_q           <= cnt_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      pwm_q           <= pwm_d;
      period_start_q  <= period_start_d;
      update_done_q   <= update_done_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign update_done  = update_done_q;

endmodule
